board_display_tx: RTL and testbench

Display-side transmitter for the minesweeper core. When the main FSM enters its display state and pulses the display request, this block takes a snapshot of the 5x5 board (mine map, cleared map, game status). It computes the neighbour-mine count for each cleared cell and streams the board as 31 ASCII bytes over a valid/ready byte interface toward the host/UART. When the last byte has been accepted it returns a one-cycle display-done pulse to the main FSM.

---
 rtl/minesweeper_pkg.sv | 15 +
 rtl/mine_neighbor_count.sv | 30 +++
 rtl/board_display_tx.sv | 147 ++++++++++++++
 tb/tb_board_display_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - shared board geometry, display characters and display FSM states
package minesweeper_pkg;
    localparam int BOARD_DIM = 5;
    localparam int N_CELLS   = 25;

    localparam logic [7:0] HIDDEN_CHAR_DEF = 8'h23;
    localparam logic [7:0] MINE_CHAR_DEF   = 8'h2A;
    localparam logic [7:0] EOL_CHAR_DEF    = 8'h0A;
    localparam logic [7:0] DIGIT_BASE      = 8'h30;
    localparam logic [7:0] STATUS_LOSE     = 8'h4C;
    localparam logic [7:0] STATUS_WIN      = 8'h57;
    localparam logic [7:0] STATUS_PLAY     = 8'h50;

    typedef enum logic [1:0] {IDLE, SEND, STATUS, DONE} disp_state_t;
endpackage

// File: rtl/mine_neighbor_count.sv
// rtl/mine_neighbor_count.sv - number of mines adjacent to one cell, edges clipped
module mine_neighbor_count
    import minesweeper_pkg::*;
(
    input  logic [N_CELLS-1:0] mines,
    input  logic [4:0]         index,
    output logic [3:0]         count
);
    int         row;
    int         col;
    logic [4:0] nb;

    always_comb begin
        row   = int'(index) / BOARD_DIM;
        col   = int'(index) % BOARD_DIM;
        count = 4'd0;
        nb    = 5'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                // Row and column are bounded separately so row ends never wrap.
                if ((dr != 0 || dc != 0) &&
                    row + dr >= 0 && row + dr < BOARD_DIM &&
                    col + dc >= 0 && col + dc < BOARD_DIM) begin
                    nb    = 5'((row + dr) * BOARD_DIM + col + dc);
                    count = count + {3'b000, mines[nb]};
                end
            end
        end
    end
endmodule

// File: rtl/board_display_tx.sv
// rtl/board_display_tx.sv - snapshots the board and streams it as 31 ASCII bytes
module board_display_tx
    import minesweeper_pkg::*;
#(
    parameter logic [7:0] HIDDEN_CHAR = HIDDEN_CHAR_DEF,
    parameter logic [7:0] MINE_CHAR   = MINE_CHAR_DEF,
    parameter logic [7:0] EOL_CHAR    = EOL_CHAR_DEF
) (
    input  logic                in_clka,
    input  logic                in_restart,
    input  logic                in_display,
    input  logic [N_CELLS-1:0]  in_mines,
    input  logic [N_CELLS-1:0]  in_cleared,
    input  logic                in_gameover,
    input  logic                in_win,
    output logic [7:0]          out_tx_data,
    output logic                out_tx_valid,
    input  logic                in_tx_ready,
    output logic                out_busy,
    output logic                out_display_done
);
    disp_state_t        state_q;
    logic [2:0]         row_q, col_q;
    logic [N_CELLS-1:0] snap_mines_q, snap_cleared_q;
    logic               snap_gameover_q, snap_win_q;
    logic [7:0]         data_q;
    logic               valid_q, busy_q, done_q;

    logic [2:0]         row_d, col_d;
    logic [N_CELLS-1:0] src_mines, src_cleared;
    logic               src_gameover;
    logic [4:0]         cell_idx;
    logic [3:0]         nbr_cnt;
    logic [7:0]         status_char;
    logic [7:0]         data_d;
    logic               last_eol;

    assign last_eol = (row_q == 3'd4) && (col_q == 3'd5);

    // Position of the byte to present next; in IDLE the first byte comes straight from the inputs.
    always_comb begin
        src_mines    = snap_mines_q;
        src_cleared  = snap_cleared_q;
        src_gameover = snap_gameover_q;
        row_d        = row_q;
        col_d        = col_q + 3'd1;
        if (state_q == IDLE) begin
            src_mines    = in_mines;
            src_cleared  = in_cleared;
            src_gameover = in_gameover;
            row_d        = 3'd0;
            col_d        = 3'd0;
        end else if (col_q == 3'd5) begin
            row_d = row_q + 3'd1;
            col_d = 3'd0;
        end
    end

    assign cell_idx = 5'(row_d) * 5'd5 + 5'(col_d);

    mine_neighbor_count u_nbr (
        .mines (src_mines),
        .index (cell_idx),
        .count (nbr_cnt)
    );

    assign status_char = snap_gameover_q ? STATUS_LOSE :
                         snap_win_q      ? STATUS_WIN  : STATUS_PLAY;

    always_comb begin
        data_d = HIDDEN_CHAR;
        if (state_q != IDLE && last_eol)
            data_d = status_char;
        else if (col_d == 3'd5)
            data_d = EOL_CHAR;
        else if (src_mines[cell_idx] && (src_cleared[cell_idx] || src_gameover))
            data_d = MINE_CHAR;
        else if (src_cleared[cell_idx])
            data_d = DIGIT_BASE + {4'b0000, nbr_cnt};
    end

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state_q         <= IDLE;
            row_q           <= 3'd0;
            col_q           <= 3'd0;
            snap_mines_q    <= '0;
            snap_cleared_q  <= '0;
            snap_gameover_q <= 1'b0;
            snap_win_q      <= 1'b0;
            data_q          <= 8'h00;
            valid_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    if (in_display) begin
                        snap_mines_q    <= in_mines;
                        snap_cleared_q  <= in_cleared;
                        snap_gameover_q <= in_gameover;
                        snap_win_q      <= in_win;
                        row_q           <= 3'd0;
                        col_q           <= 3'd0;
                        data_q          <= data_d;
                        valid_q         <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= SEND;
                    end
                end
                SEND: begin
                    if (in_tx_ready) begin
                        data_q <= data_d;
                        row_q  <= row_d;
                        col_q  <= col_d;
                        if (last_eol) begin
                            row_q   <= row_q;
                            col_q   <= col_q;
                            state_q <= STATUS;
                        end
                    end
                end
                STATUS: begin
                    if (in_tx_ready) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_tx_data      = data_q;
    assign out_tx_valid     = valid_q;
    assign out_busy         = busy_q;
    assign out_display_done = done_q;
endmodule

// File: tb/tb_board_display_tx.sv
// tb/tb_board_display_tx.sv - randomized bench for board_display_tx against a board-level model
module tb_board_display_tx;
    logic        clk = 1'b0;
    logic        in_restart = 1'b1;
    logic        in_display = 1'b0;
    logic [24:0] in_mines = '0;
    logic [24:0] in_cleared = '0;
    logic        in_gameover = 1'b0;
    logic        in_win = 1'b0;
    logic [7:0]  out_tx_data;
    logic        out_tx_valid;
    logic        in_tx_ready = 1'b1;
    logic        out_busy;
    logic        out_display_done;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  exp_b [31];
    logic [7:0]  rx_b  [31];

    always #5 clk = ~clk;

    board_display_tx dut (
        .in_clka          (clk),
        .in_restart       (in_restart),
        .in_display       (in_display),
        .in_mines         (in_mines),
        .in_cleared       (in_cleared),
        .in_gameover      (in_gameover),
        .in_win           (in_win),
        .out_tx_data      (out_tx_data),
        .out_tx_valid     (out_tx_valid),
        .in_tx_ready      (in_tx_ready),
        .out_busy         (out_busy),
        .out_display_done (out_display_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Board model: mines on a zero-padded 7x7 grid, each count is a 3x3 window sum minus the centre.
    task automatic build_exp(input logic [24:0] m, input logic [24:0] c, input logic go, input logic w);
        int grid [7][7];
        int n;
        int i;
        for (int r = 0; r < 7; r++)
            for (int k = 0; k < 7; k++)
                grid[r][k] = 0;
        for (int j = 0; j < 25; j++)
            grid[j / 5 + 1][j % 5 + 1] = int'(m[j]);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 6; k++) begin
                if (k == 5) begin
                    exp_b[r * 6 + k] = 8'h0A;
                end else begin
                    i = r * 5 + k;
                    n = -grid[r + 1][k + 1];
                    for (int a = 0; a < 3; a++)
                        for (int b = 0; b < 3; b++)
                            n += grid[r + a][k + b];
                    if (m[i] && (c[i] || go)) exp_b[r * 6 + k] = 8'h2A;
                    else if (c[i])            exp_b[r * 6 + k] = 8'(32'h30 + n);
                    else                      exp_b[r * 6 + k] = 8'h23;
                end
            end
        end
        exp_b[30] = go ? 8'h4C : (w ? 8'h57 : 8'h50);
    endtask

    task automatic run_frame(input string tag, input logic [24:0] m, input logic [24:0] c,
                             input logic go, input logic w, input int stall_at, input int stall_len,
                             input bit rand_rdy, input bit poke);
        int idx = 0, stalls = 0, fix_st = 0, dones = 0, done_cyc = -1;
        int busy_bad = 0, hold_bad = 0;
        bit stall, prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        build_exp(m, c, go, w);
        for (int j = 0; j < 31; j++) rx_b[j] = 8'hFF;
        @(negedge clk);
        in_mines = m; in_cleared = c; in_gameover = go; in_win = w;
        in_display = 1'b1; in_tx_ready = 1'b1;
        @(negedge clk);
        in_display = 1'b0;
        in_mines = 25'($urandom); in_cleared = 25'($urandom);
        in_gameover = 1'($urandom); in_win = 1'($urandom);
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (out_display_done === 1'b1) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_busy !== ((done_cyc < 0) || (cyc <= done_cyc))) busy_bad++;
            if (prev_stall && (out_tx_valid !== 1'b1 || out_tx_data !== prev_data)) hold_bad++;
            if (poke && cyc == 12) begin
                in_display = 1'b1;
                in_cleared = ~c;
            end
            if (poke && cyc == 13) in_display = 1'b0;
            if (out_tx_valid === 1'b1) begin
                stall = (idx == stall_at && fix_st < stall_len) ||
                        (rand_rdy && stalls < 20 && $urandom_range(3) == 0);
                if (idx == stall_at && fix_st < stall_len) fix_st++;
                in_tx_ready = !stall;
                if (stall) begin
                    stalls++;
                    prev_stall = 1'b1;
                    prev_data = out_tx_data;
                end else begin
                    if (idx < 31) begin
                        rx_b[idx] = out_tx_data;
                        check($sformatf("%s.byte%0d", tag, idx), 32'(out_tx_data), 32'(exp_b[idx]));
                    end
                    idx++;
                    prev_stall = 1'b0;
                end
            end else begin
                in_tx_ready = 1'($urandom);
                prev_stall = 1'b0;
            end
            @(negedge clk);
        end
        in_tx_ready = 1'b1;
        check({tag, ".nbytes"}, idx, 31);
        check({tag, ".ndone"}, dones, 1);
        check({tag, ".done_cycle"}, done_cyc, 32 + stalls);
        check({tag, ".busy"}, busy_bad, 0);
        check({tag, ".hold"}, hold_bad, 0);
    endtask

    task automatic restart_test();
        int idx = 0, dones = 0;
        @(negedge clk);
        in_mines = 25'($urandom); in_cleared = 25'($urandom); in_gameover = 1'b0; in_win = 1'b0;
        in_display = 1'b1; in_tx_ready = 1'b1;
        @(negedge clk);
        in_display = 1'b0;
        for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
            if (out_tx_valid === 1'b1) idx++;
            @(negedge clk);
        end
        check("rst.reached_byte10", idx, 10);
        in_restart = 1'b1;
        @(negedge clk);
        in_restart = 1'b0;
        check("rst.valid", 32'(out_tx_valid), 0);
        check("rst.busy", 32'(out_busy), 0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_display_done !== 1'b0 || out_tx_valid !== 1'b0) dones++;
            @(negedge clk);
        end
        check("rst.no_done_or_valid", dones, 0);
    endtask

    initial begin
        int bad = 0;
        in_mines = 25'($urandom); in_cleared = 25'($urandom);
        in_gameover = 1'($urandom); in_win = 1'($urandom); in_display = 1'($urandom);
        repeat (2) @(negedge clk);
        check("reset.data", 32'(out_tx_data), 0);
        check("reset.valid", 32'(out_tx_valid), 0);
        check("reset.busy", 32'(out_busy), 0);
        check("reset.done", 32'(out_display_done), 0);
        in_restart = 1'b0;
        in_display = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_tx_valid !== 1'b0 || out_busy !== 1'b0) bad++;
        end
        check("idle.no_valid", bad, 0);

        run_frame("nbr", 25'h61, 25'h12, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        check("nbr.cell4", 32'(rx_b[4]), 32'h30);
        check("nbr.eol0", 32'(rx_b[5]), 32'h0A);
        check("nbr.cell5", 32'(rx_b[6]), 32'h23);
        check("nbr.status", 32'(rx_b[30]), 32'h50);

        run_frame("over", 25'h1000, 25'h1000, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        check("over.mine", 32'(rx_b[14]), 32'h2A);
        check("over.eol11", 32'(rx_b[11]), 32'h0A);
        check("over.eol17", 32'(rx_b[17]), 32'h0A);
        check("over.eol29", 32'(rx_b[29]), 32'h0A);
        check("over.status", 32'(rx_b[30]), 32'h4C);

        run_frame("bp", 25'($urandom), 25'($urandom), 1'b0, 1'b1, 7, 3, 1'b0, 1'b0);

        restart_test();
        run_frame("after_rst", 25'($urandom), 25'($urandom), 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);

        run_frame("snap", 25'($urandom), 25'($urandom), 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);

        for (int f = 0; f < 5; f++)
            run_frame($sformatf("rand%0d", f), 25'($urandom), 25'($urandom),
                      1'($urandom), 1'($urandom), -1, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
